// File: rtl/accum_rr_sched.sv
// -----------------------------------------------------------------------------
// accum_rr_sched
//   Round-robin scheduler sharing one WIDTH-bit accumulator among NREQ
//   requesters. Each accepted addend walks a fixed IDLE -> WAIT -> ADD
//   sequence. A grant happens in IDLE, and the add commits on the ADD edge.
//
// Ports
//   CLK        clock
//   RST        synchronous, active-high reset (priority over clear)
//   enable     gates new grants only; an in-flight add still completes
//   clear      synchronous clear of accumulator/overflow, aborts in-flight add
//   req_valid  per-requester valid
//   req_value  addends, requester k at [k*WIDTH +: WIDTH]
//   req_ready  one-hot accept (combinational)
//   acc_value  registered running sum
//   led        acc_value[23:16]
//   grant_id   index of the last accepted requester
//   busy       high while in WAIT or ADD
//   done       one-cycle pulse after an add commits
//   overflow   sticky carry-out flag
// -----------------------------------------------------------------------------
module accum_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int GW    = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_value,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      acc_value,
  output logic [7:0]            led,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [GW-1:0]    r_last;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_winner;
  logic             w_found;
  logic             w_grant;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_sel_value;
  logic [WIDTH:0]   w_sum;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  // Round-robin search starting just after the most recent grant.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_sel_value = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && req_valid[(int'(r_last) + i) % NREQ]) begin
        w_found     = 1'b1;
        w_winner    = GW'((int'(r_last) + i) % NREQ);
        w_sel_value = req_value[((int'(r_last) + i) % NREQ) * WIDTH +: WIDTH];
      end
    end
  end

  // clear suppresses a grant in the same cycle it aborts everything else.
  assign w_grant   = (r_state == S_IDLE) && enable && !clear && w_found;
  assign req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_grant) w_next = S_WAIT;
        S_WAIT:  w_next = S_ADD;
        S_ADD:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // One extra bit keeps the carry-out of the add for the overflow flag.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_op};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= '0;
      r_last  <= GW'(NREQ - 1);
      r_grant <= '0;
    end else if (clear) begin
      // Pointer and grant_id survive a clear; only the datapath is wiped.
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_ADD);
      if (r_state == S_ADD) begin
        r_acc <= w_sum[WIDTH-1:0];
        if (w_sum[WIDTH]) r_ovf <= 1'b1;
      end
      if (w_grant) begin
        r_op    <= w_sel_value;
        r_last  <= w_winner;
        r_grant <= w_winner;
      end
    end
  end

  assign acc_value = r_acc;
  assign led       = r_acc[23:16];
  assign grant_id  = r_grant;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_accum_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_accum_rr_sched
//   Directed scenarios plus a randomized run for accum_rr_sched (NREQ=4,
//   WIDTH=32). The reference model is transaction/timing based: an accepted
//   addend is scheduled to land a fixed number of cycles later, and the
//   next accept is allowed from a "free" cycle onward.
// -----------------------------------------------------------------------------
module tb_accum_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int GW    = 2;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  enable;
  logic                  clear;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_value;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      acc_value;
  logic [7:0]            led;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  accum_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .GW(GW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .clear(clear),
    .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
    .acc_value(acc_value), .led(led), .grant_id(grant_id),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_acc;
  logic        m_ovf, m_done, m_busy;
  logic [1:0]  m_gid;
  int          m_last;
  logic        m_pend;
  logic [31:0] m_val;
  int          m_commit;  // cycle whose closing edge commits the pending add
  int          m_free;    // first cycle a new accept is allowed
  int          m_cyc;
  logic [3:0]  m_ready;

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_ovf = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    m_gid = '0; m_last = 3; m_pend = 1'b0; m_free = m_cyc;
  endtask

  task automatic model_comb();
    int w;
    m_ready = '0;
    if (!RST && !clear && enable && m_cyc >= m_free) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) m_ready[w] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [32:0] s;
    if (RST) begin
      model_reset();
    end else if (clear) begin
      m_acc = '0; m_ovf = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      m_pend = 1'b0; m_free = m_cyc + 1;
    end else begin
      m_done = 1'b0;
      if (m_pend && m_commit == m_cyc) begin
        s = {1'b0, m_acc} + {1'b0, m_val};
        m_acc = s[31:0];
        if (s[32]) m_ovf = 1'b1;
        m_done = 1'b1;
        m_pend = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (m_ready[k]) begin
          m_val = req_value[k*32 +: 32];
          m_pend = 1'b1; m_commit = m_cyc + 2; m_free = m_cyc + 3;
          m_last = k; m_gid = 2'(k);
        end
      end
      m_busy = m_pend && (m_cyc + 1 <= m_commit);
    end
    m_cyc++;
  endtask

  // Inputs are driven 1 time unit after a rising edge; settle lets the
  // combinational req_ready resolve before it is sampled.
  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic tick();
    model_comb();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; clear = 1'b0; enable = 1'b1; req_valid = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Drives one addend through requester k and stops in the cycle done shows.
  task automatic do_add(input int k, input logic [31:0] v);
    req_valid = '0;
    req_valid[k] = 1'b1;
    req_value[k*32 +: 32] = v;
    settle();
    tick();
    req_valid[k] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    req_value = '0;
    do_reset();
    settle();
    n_cmp++; if (acc_value !== 32'd0) begin n_err++; $display("FAIL reset_acc: got %h expected 0", acc_value); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_value[2*32 +: 32] = 32'h0001_0000;
    settle();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick(); tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b expected 1", done); end
    n_cmp++; if (acc_value !== 32'h0001_0000) begin n_err++; $display("FAIL single_acc: got %h expected 00010000", acc_value); end
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL single_led: got %h expected 01", led); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_gid: got %0d expected 2", grant_id); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) req_value[k*32 +: 32] = 32'(k + 1);
    for (int g = 0; g < 8; g++) begin
      exp = 4'b0001 << (g % 4);
      settle();
      n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL fair_grant%0d: got %b expected %b", g, req_ready, exp); end
      tick();
      if (g == 7) req_valid = '0;
      settle();
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL fair_wait%0d: got %b expected 0000", g, req_ready); end
      tick();
      settle();
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL fair_add%0d: got %b expected 0000", g, req_ready); end
      tick();
    end
    n_cmp++; if (acc_value !== 32'd20) begin n_err++; $display("FAIL fair_acc: got %0d expected 20", acc_value); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fair_done: got %b expected 1", done); end
    n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL fair_gid: got %0d expected 3", grant_id); end
  endtask

  task automatic test_overflow();
    do_reset();
    do_add(0, 32'hFFFF_FFFE);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
    do_add(1, 32'd3);
    n_cmp++; if (acc_value !== 32'd1) begin n_err++; $display("FAIL ovf_acc1: got %h expected 1", acc_value); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    do_add(2, 32'd1);
    n_cmp++; if (acc_value !== 32'd2) begin n_err++; $display("FAIL ovf_acc2: got %h expected 2", acc_value); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (acc_value !== 32'd0) begin n_err++; $display("FAIL ovf_clr_acc: got %h expected 0", acc_value); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_flag: got %b expected 0", overflow); end
  endtask

  task automatic test_clear_during_add();
    do_reset();
    do_add(0, 32'd10);
    req_valid = 4'b0010;
    req_value[1*32 +: 32] = 32'd5;
    settle();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL clr_accept: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    // ADD cycle: clear with another requester waiting.
    clear = 1'b1;
    req_valid = 4'b0100;
    req_value[2*32 +: 32] = 32'd9;
    settle();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL clr_ready_add: got %b expected 0000", req_ready); end
    tick();
    n_cmp++; if (acc_value !== 32'd0) begin n_err++; $display("FAIL clr_acc: got %h expected 0", acc_value); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_done: got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b expected 0", busy); end
    settle();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL clr_ready_idle: got %b expected 0000", req_ready); end
    tick();
    clear = 1'b0;
    settle();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL clr_idle_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    n_cmp++; if (acc_value !== 32'd9) begin n_err++; $display("FAIL clr_after: got %0d expected 9", acc_value); end
  endtask

  task automatic test_enable_gating();
    do_reset();
    req_valid = 4'b0010;
    req_value[1*32 +: 32] = 32'd6;
    settle();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL en_first: got %b expected 0010", req_ready); end
    tick();
    enable = 1'b0;
    tick(); tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL en_done: got %b expected 1", done); end
    n_cmp++; if (acc_value !== 32'd6) begin n_err++; $display("FAIL en_acc: got %0d expected 6", acc_value); end
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL en_gated%0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    enable = 1'b1;
    settle();
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL en_regrant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    n_cmp++; if (acc_value !== 32'd12) begin n_err++; $display("FAIL en_acc2: got %0d expected 12", acc_value); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_add(0, 32'd100);
    req_valid = 4'b0010;
    req_value[1*32 +: 32] = 32'd7;
    settle();
    tick();
    req_valid = '0;
    RST = 1'b1;  // WAIT cycle
    tick();
    RST = 1'b0;
    settle();
    n_cmp++; if (acc_value !== 32'd0) begin n_err++; $display("FAIL rst_acc: got %0d expected 0", acc_value); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_no_done: got %b expected 0", done); end
    req_valid = 4'b1001;
    req_value[0 +: 32]    = 32'd11;
    req_value[3*32 +: 32] = 32'd22;
    settle();
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_prio: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
    n_cmp++; if (acc_value !== 32'd11) begin n_err++; $display("FAIL rst_acc2: got %0d expected 11", acc_value); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      RST    = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < 4; k++) begin
        if (req_valid[k] && !m_ready[k]) begin
          if ($urandom_range(0, 9) == 0) req_valid[k] = 1'b0;
        end else begin
          req_valid[k] = ($urandom_range(0, 2) == 0);
          req_value[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'hC000_0000) : $urandom;
        end
      end
      settle();
      if (!RST) begin
        n_cmp++; if (req_ready !== m_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, req_ready, m_ready); end
      end
      tick();
      n_cmp++; if (acc_value !== m_acc) begin n_err++; $display("FAIL rnd_acc@%0d: got %h expected %h", c, acc_value, m_acc); end
      n_cmp++; if (led !== m_acc[23:16]) begin n_err++; $display("FAIL rnd_led@%0d: got %h expected %h", c, led, m_acc[23:16]); end
      n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b expected %b", c, overflow, m_ovf); end
      n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rnd_done@%0d: got %b expected %b", c, done, m_done); end
      n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, m_busy); end
      n_cmp++; if (grant_id !== m_gid) begin n_err++; $display("FAIL rnd_gid@%0d: got %0d expected %0d", c, grant_id, m_gid); end
    end
    RST = 1'b0; clear = 1'b0; enable = 1'b1; req_valid = '0;
  endtask

  initial begin
    m_cyc = 0;
    m_ready = '0;
    RST = 1'b1; enable = 1'b1; clear = 1'b0; req_valid = '0; req_value = '0;
    model_reset();
    @(posedge CLK);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_clear_during_add();
    test_enable_gating();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accum_rr_sched.md
# accum_rr_sched

Round-robin scheduler that shares a single 32-bit accumulator among NREQ requesters. Each requester offers an addend over a valid/ready handshake. The block grants one requester at a time and sequences the accumulator through a fixed IDLE → WAIT → ADD cycle. It exposes the running sum, an LED byte and status flags, and sits in front of the accumulate/LED datapath in `top`-level designs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: addend and accumulator width, at least 24.
- `GW`, clog2(NREQ): grant index width.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-high.
- `enable` in 1: when low, no new grants are issued; an in-flight operation still completes.
- `clear` in 1: synchronous clear of the accumulator and the overflow flag.
- `req_valid` in NREQ: per-requester valid.
- `req_value` in NREQ*WIDTH: addends; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_ready` out NREQ: one-hot accept; combinational from state, `enable`, `clear` and `req_valid`.
- `acc_value` out WIDTH: registered running sum.
- `led` out 8: `acc_value[23:16]`, combinational.
- `grant_id` out GW: index of the last accepted requester, registered.
- `busy` out 1: high in WAIT and ADD.
- `done` out 1: one-cycle registered pulse when an add commits.
- `overflow` out 1: sticky; set on carry-out of an add.

## Operation
- States:
  - IDLE: accept one request and capture its operand.
  - WAIT: one idle cycle.
  - ADD: commit the captured operand to the accumulator.
- Round-robin arbitration:
  - A pointer `last` holds the index of the most recent grant.
  - Search order is `last+1`, `last+2`, …, wrapping modulo NREQ.
  - The first requester with `req_valid` set wins.
- IDLE behaviour:
  - Grant condition: `enable=1`, `clear=0` and any `req_valid` set.
  - On grant: `req_ready[winner]=1`. The transfer completes at that clock edge.
  - The same edge latches `req_value[winner]` into `op`, sets `last`/`grant_id` to the winner and moves to WAIT.
  - Otherwise `req_ready` is all zero and the FSM stays in IDLE.
- WAIT: always moves to ADD. `req_ready` is all zero.
- ADD:
  - `acc_value <= acc_value + op`, truncated to WIDTH.
  - If the carry-out is 1, `overflow <= 1`.
  - `done <= 1` on the same edge.
  - Next state is IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is silent apart from `overflow`.
- `clear=1` has priority over everything, in any state:
  - `acc_value <= 0` and `overflow <= 0`.
  - The FSM goes to IDLE and any in-flight operation is discarded: no add, no `done`.
  - `req_ready` is all zero in that cycle.
  - `grant_id` and `last` are kept.
- `enable` falling during WAIT or ADD: the operation completes normally; no further grants until `enable=1`.
- Requesters must hold `req_valid` and `req_value` stable until accepted. Dropping `req_valid` before acceptance is legal; the request is simply not served.

## Timing
- Reset values:
  - state IDLE.
  - `acc_value=0`, `overflow=0`, `done=0`, `busy=0`, `grant_id=0`, `req_ready=0`.
  - `last=NREQ-1`, so requester 0 has first priority after reset.
- Latency: for a handshake in cycle t, the FSM is in WAIT at t+1 and ADD at t+2. The new `acc_value`, `led` and `done=1` are visible in cycle t+3.
- Throughput: at most one accept per 3 cycles. The next accept can occur in cycle t+3, the same cycle `done` is high.
- `busy` is registered from the state: high in cycles t+1 and t+2.
- `RST` asserted mid-operation:
  - All registers return to their reset values at that edge.
  - The in-flight add is lost.
  - `RST` has priority over `clear`.

## Test plan
- **Single request:** after reset, `req_valid[2]=1` with `value=0x0001_0000` in cycle 0.
  - `req_ready[2]=1` in cycle 0.
  - `done=1` and `acc_value=0x0001_0000` in cycle 3.
  - `led=0x01`, `grant_id=2`.
- **Fairness:** all four requesters valid continuously with values 1, 2, 3, 4.
  - Grant order is 0, 1, 2, 3, 0, …, one grant every 3 cycles.
  - After 8 grants, `acc_value=20`.
- **Overflow:** preload `acc_value=0xFFFF_FFFE`, then add 3.
  - `acc_value=1` and `overflow=1`.
  - A subsequent add of 1 gives `acc_value=2` with `overflow` still 1.
  - Then `clear` gives `acc_value=0` and `overflow=0`.
- **Clear during ADD:** `clear=1` in the ADD cycle of an add of 5 onto 10.
  - Next cycle: `acc_value=0`, `done=0`, state IDLE.
  - No `req_ready` is asserted in the clear cycle.
- **Enable gating:** `enable` falls in the WAIT cycle with `req_valid[1]` held.
  - The current add completes with `done=1`.
  - `req_ready` stays 0 while `enable=0`.
  - The grant occurs in the first cycle `enable=1`.
- **Reset mid-operation:** `RST` in WAIT after accepting 7 onto 100.
  - `acc_value=0`, `busy=0`, no `done`.
  - The next grant with requesters 0 and 3 both valid goes to 0.
